pb_cond: RTL and testbench

- Input-side conditioning front end for the two player pushbuttons; the counterpart of the LED output path.
- Synchronizes and debounces the raw left and right buttons.
- Arbitrates which button was pressed first during a round window opened by master control.
- Emits exactly one registered single-cycle event per round: pushl, pushr or tie. These feed the push latch and scorer path in place of raw button levels.

---
 rtl/pb_cond.sv | 166 ++++++++++++++++
 tb/tb_pb_cond.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pb_cond.sv
// ---------------------------------------------------------------------------
// pb_cond : pushbutton conditioning front end for the two-player game.
//
// Takes the raw, asynchronous left/right pushbuttons, synchronizes them into
// the clk domain, debounces them on the slow tick, and arbitrates which
// player pressed first during a round window opened by master control.
// Exactly one registered single-cycle event (pushl, pushr or tie) is emitted
// per armed round; these replace the raw button levels on the scorer path.
//
// Parameters:
//   DB_COUNT : consecutive tick samples a button must disagree with its
//              debounced level before that level flips (1..15).
//
// Ports:
//   clk     in   system clock (divided clock domain)
//   rst     in   asynchronous active-low reset
//   tick    in   debounce sample enable, one-cycle pulse
//   arm     in   round window from master control
//   pbl_raw in   raw left button, active high, asynchronous
//   pbr_raw in   raw right button, active high, asynchronous
//   pushl   out  one-cycle pulse, left pressed first this round
//   pushr   out  one-cycle pulse, right pressed first this round
//   tie     out  one-cycle pulse, both presses qualified in the same cycle
//   held_l  out  debounced left level
//   held_r  out  debounced right level
//   locked  out  high while the round result is captured
// ---------------------------------------------------------------------------
module pb_cond #(
    parameter int DB_COUNT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic arm,
    input  logic pbl_raw,
    input  logic pbr_raw,
    output logic pushl,
    output logic pushr,
    output logic tie,
    output logic held_l,
    output logic held_r,
    output logic locked
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ARMED  = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    localparam logic [3:0] CNT_MAX = 4'(DB_COUNT - 1);

    // Bit 0 is the left button, bit 1 the right button throughout.
    logic [1:0] r_syncA;
    logic [1:0] r_syncB;
    logic [1:0] r_held;
    logic [1:0] r_heldDly;
    logic [3:0] r_cnt [2];

    logic [1:0] r_state;
    logic [1:0] w_stateNext;
    logic       r_pushl;
    logic       r_pushr;
    logic       r_tie;
    logic       w_pushlNext;
    logic       w_pushrNext;
    logic       w_tieNext;
    logic [1:0] w_rise;

    // Two-flop synchronizer feeding a per-button debounce counter. The
    // counter only advances on tick cycles and restarts whenever the
    // synchronized level agrees with the debounced level again, so any
    // bounce shorter than DB_COUNT consecutive ticks is swallowed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_syncA   <= '0;
            r_syncB   <= '0;
            r_held    <= '0;
            r_heldDly <= '0;
            for (int i = 0; i < 2; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_syncA   <= {pbr_raw, pbl_raw};
            r_syncB   <= r_syncA;
            r_heldDly <= r_held;
            if (tick) begin
                for (int i = 0; i < 2; i++) begin
                    if (r_syncB[i] == r_held[i]) begin
                        r_cnt[i] <= '0;
                    end else if (r_cnt[i] == CNT_MAX) begin
                        r_held[i] <= r_syncB[i];
                        r_cnt[i]  <= '0;
                    end else begin
                        r_cnt[i] <= r_cnt[i] + 4'd1;
                    end
                end
            end
        end
    end

    // A qualified press is the single cycle right after the debounced level
    // went 0->1; releases produce nothing.
    assign w_rise = r_held & ~r_heldDly;

    // Round arbitration. Arming is refused while either button is still
    // down so a pre-pressed button earns no credit. Dropping arm beats a
    // simultaneous rise, and LOCKED ignores the buttons entirely.
    always_comb begin
        w_stateNext = r_state;
        w_pushlNext = 1'b0;
        w_pushrNext = 1'b0;
        w_tieNext   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (arm && (r_held == 2'b00)) begin
                    w_stateNext = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (!arm) begin
                    w_stateNext = ST_IDLE;
                end else if (w_rise == 2'b11) begin
                    w_tieNext   = 1'b1;
                    w_stateNext = ST_LOCKED;
                end else if (w_rise == 2'b01) begin
                    w_pushlNext = 1'b1;
                    w_stateNext = ST_LOCKED;
                end else if (w_rise == 2'b10) begin
                    w_pushrNext = 1'b1;
                    w_stateNext = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (!arm) begin
                    w_stateNext = ST_IDLE;
                end
            end
            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
    end

    // State and event registers; the events are one-cycle pulses because
    // the FSM leaves ARMED in the same cycle it raises one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_pushl <= 1'b0;
            r_pushr <= 1'b0;
            r_tie   <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            r_pushl <= w_pushlNext;
            r_pushr <= w_pushrNext;
            r_tie   <= w_tieNext;
        end
    end

    assign pushl  = r_pushl;
    assign pushr  = r_pushr;
    assign tie    = r_tie;
    assign held_l = r_held[0];
    assign held_r = r_held[1];
    assign locked = (r_state == ST_LOCKED);

endmodule

// File: tb/tb_pb_cond.sv
// Testbench for pb_cond: directed scenarios plus a randomized phase, all
// checked every cycle against a behavioural model of the button front end.
module tb_pb_cond;

   localparam int DB = 4;

   logic clk;
   logic rst;
   logic tick;
   logic arm;
   logic pblRaw;
   logic pbrRaw;
   logic pushl;
   logic pushr;
   logic tie;
   logic heldL;
   logic heldR;
   logic locked;

   int checks   = 0;
   int failures = 0;
   int tickMode = 0;
   int divCnt   = 0;

   pb_cond #(.DB_COUNT(DB)) dut (
      .clk(clk),
      .rst(rst),
      .tick(tick),
      .arm(arm),
      .pbl_raw(pblRaw),
      .pbr_raw(pbrRaw),
      .pushl(pushl),
      .pushr(pushr),
      .tie(tie),
      .held_l(heldL),
      .held_r(heldR),
      .locked(locked)
   );

   // 10 time-unit clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Behavioural model: each button has a 2-deep arrival pipe, a debounced
   // level and a run length of consecutive disagreeing ticks. A round is a
   // phase (idle / waiting for first press / result captured).
   typedef enum int {PhIdle, PhWaiting, PhCaptured} phase_t;

   phase_t mPhase;
   bit     mPipe0 [2];
   bit     mPipe1 [2];
   bit     mHeld [2];
   int     mRun [2];
   bit     mFreshPress [2];
   bit     mPushl;
   bit     mPushr;
   bit     mTie;

   // Advance the model once per clock using the inputs as seen at the edge.
   always @(posedge clk or negedge rst) begin
      bit nowPressed [2];
      bit rawIn [2];
      if (!rst) begin
         mPhase = PhIdle;
         mPushl = 0;
         mPushr = 0;
         mTie   = 0;
         for (int b = 0; b < 2; b++) begin
            mPipe0[b] = 0;
            mPipe1[b] = 0;
            mHeld[b]  = 0;
            mRun[b]   = 0;
            mFreshPress[b] = 0;
         end
      end else begin
         nowPressed = mFreshPress;
         rawIn[0] = pblRaw;
         rawIn[1] = pbrRaw;
         mPushl = 0;
         mPushr = 0;
         mTie   = 0;
         if (mPhase == PhIdle) begin
            if (arm && !mHeld[0] && !mHeld[1]) mPhase = PhWaiting;
         end else if (mPhase == PhWaiting) begin
            if (!arm) mPhase = PhIdle;
            else if (nowPressed[0] || nowPressed[1]) begin
               mTie   = nowPressed[0] && nowPressed[1];
               mPushl = nowPressed[0] && !nowPressed[1];
               mPushr = nowPressed[1] && !nowPressed[0];
               mPhase = PhCaptured;
            end
         end else begin
            if (!arm) mPhase = PhIdle;
         end
         for (int b = 0; b < 2; b++) begin
            mFreshPress[b] = 0;
            if (tick) begin
               if (mPipe1[b] != mHeld[b]) begin
                  mRun[b]++;
                  if (mRun[b] >= DB) begin
                     mFreshPress[b] = mPipe1[b];
                     mHeld[b] = mPipe1[b];
                     mRun[b]  = 0;
                  end
               end else begin
                  mRun[b] = 0;
               end
            end
            mPipe1[b] = mPipe0[b];
            mPipe0[b] = rawIn[b];
         end
      end
   end

   task automatic checkOutput(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%0b expected=%0b time=%0t", name, act, exp, $time);
      end
   endtask

   // Single compare process: every cycle, away from the active edge.
   always @(posedge clk) begin
      #2;
      checkOutput("model_pushl", pushl, mPushl);
      checkOutput("model_pushr", pushr, mPushr);
      checkOutput("model_tie", tie, mTie);
      checkOutput("model_held_l", heldL, mHeld[0]);
      checkOutput("model_held_r", heldR, mHeld[1]);
      checkOutput("model_locked", locked, mPhase == PhCaptured);
   end

   // Step n clocks; inputs change 2 time units after each active edge.
   task automatic applyStimulus(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #2;
         divCnt = (divCnt + 1) % 256;
         case (tickMode)
            0: tick = 1'b1;
            1: tick = 1'($urandom_range(0, 1));
            default: tick = (divCnt == 0);
         endcase
      end
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_pushl"}, pushl, 1'b0);
      checkOutput({tag, "_pushr"}, pushr, 1'b0);
      checkOutput({tag, "_tie"}, tie, 1'b0);
      checkOutput({tag, "_held_l"}, heldL, 1'b0);
      checkOutput({tag, "_held_r"}, heldR, 1'b0);
      checkOutput({tag, "_locked"}, locked, 1'b0);
   endtask

   initial begin
      int budget;
      rst    = 1'b0;
      tick   = 1'b1;
      arm    = 1'b1;
      pblRaw = 1'b0;
      pbrRaw = 1'b0;
      #1;
      checkAllZero("reset");
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b1;

      // Left press at cycle 10: held_l at 16, pushl at 17
      applyStimulus(10);
      pblRaw = 1'b1;
      applyStimulus(5);
      checkOutput("lat_held_l_c15", heldL, 1'b0);
      applyStimulus(1);
      checkOutput("lat_held_l_c16", heldL, 1'b1);
      checkOutput("lat_pushl_c16", pushl, 1'b0);
      applyStimulus(1);
      checkOutput("lat_pushl_c17", pushl, 1'b1);
      checkOutput("lat_locked_c17", locked, 1'b1);
      checkOutput("lat_pushr_c17", pushr, 1'b0);
      applyStimulus(1);
      checkOutput("lat_pushl_c18", pushl, 1'b0);
      checkOutput("lat_locked_c18", locked, 1'b1);

      // Re-arm, then a 3-tick right glitch must not qualify
      pblRaw = 1'b0;
      arm = 1'b0;
      applyStimulus(12);
      arm = 1'b1;
      applyStimulus(2);
      pbrRaw = 1'b1;
      applyStimulus(3);
      pbrRaw = 1'b0;
      applyStimulus(10);
      checkOutput("glitch_held_r", heldR, 1'b0);
      checkOutput("glitch_locked", locked, 1'b0);

      // Simultaneous presses -> tie
      pblRaw = 1'b1;
      pbrRaw = 1'b1;
      applyStimulus(7);
      checkOutput("tie_pulse", tie, 1'b1);
      checkOutput("tie_pushl", pushl, 1'b0);
      checkOutput("tie_pushr", pushr, 1'b0);
      checkOutput("tie_locked", locked, 1'b1);
      applyStimulus(1);
      checkOutput("tie_single", tie, 1'b0);

      // Right held before arm rises: no arming until released
      pblRaw = 1'b0;
      pbrRaw = 1'b0;
      arm = 1'b0;
      applyStimulus(12);
      pbrRaw = 1'b1;
      applyStimulus(10);
      arm = 1'b1;
      applyStimulus(10);
      checkOutput("prepress_locked", locked, 1'b0);
      checkOutput("prepress_pushr", pushr, 1'b0);
      pbrRaw = 1'b0;
      applyStimulus(10);
      checkOutput("prepress_release", heldR, 1'b0);
      pbrRaw = 1'b1;
      applyStimulus(7);
      checkOutput("prepress_pushr_late", pushr, 1'b1);

      // Hammer both buttons while locked
      for (int k = 0; k < 50; k++) begin
         pblRaw = 1'($urandom_range(0, 1));
         pbrRaw = 1'($urandom_range(0, 1));
         applyStimulus(1);
      end
      checkOutput("hammer_locked", locked, 1'b1);
      pblRaw = 1'b0;
      pbrRaw = 1'b0;
      arm = 1'b0;
      applyStimulus(12);
      arm = 1'b1;
      applyStimulus(2);
      pblRaw = 1'b1;
      applyStimulus(7);
      checkOutput("rearm_pushl", pushl, 1'b1);
      applyStimulus(1);
      checkOutput("rearm_pushl_once", pushl, 1'b0);

      // Randomized phase: bouncy buttons, random ticks, occasional arm flips
      tickMode = 1;
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(0, 7) == 0) pblRaw = ~pblRaw;
         if ($urandom_range(0, 7) == 0) pbrRaw = ~pbrRaw;
         if ($urandom_range(0, 39) == 0) arm = ~arm;
         applyStimulus(1);
      end

      // Slow tick, reset in the middle of a debounce count
      tickMode = 0;
      pblRaw = 1'b0;
      pbrRaw = 1'b0;
      arm = 1'b0;
      applyStimulus(20);
      arm = 1'b1;
      applyStimulus(2);
      tickMode = 2;
      divCnt = 0;
      tick = 1'b0;
      pblRaw = 1'b1;
      applyStimulus(3 * 256 + 50);
      checkOutput("slow_3ticks_held_l", heldL, 1'b0);
      #3;
      rst = 1'b0;
      #1;
      checkAllZero("async_reset");
      @(posedge clk);
      #2;
      rst = 1'b1;
      applyStimulus(3 * 256 + 50);
      checkOutput("slow_after_reset_held_l", heldL, 1'b0);
      checkOutput("slow_after_reset_pushl", pushl, 1'b0);
      budget = 600;
      while (pushl !== 1'b1 && budget > 0) begin
         applyStimulus(1);
         budget--;
      end
      checkOutput("slow_fresh_pushl", pushl, 1'b1);
      applyStimulus(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
